// File: rtl/piso_serializer_param_if.sv
// piso_serializer_param_if: parallel word handshake plus the serial-side qualifiers of the PISO serializer.
interface piso_serializer_param_if #(parameter int DATA_W = 10);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              serial_out;
   logic              serial_valid;
   logic              frame_start;
   logic              busy;
   modport master (output in_data, in_valid, input in_ready, serial_out, serial_valid, frame_start, busy);
   modport slave  (input in_data, in_valid, output in_ready, serial_out, serial_valid, frame_start, busy);
endinterface

// File: rtl/piso_serializer_param.sv
// piso_serializer_param: parameterised PISO with valid/ready input and a one-word holding buffer.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer_param #(
   parameter int DATA_W    = 10,
   parameter bit MSB_FIRST = 1'b0,
   parameter bit IDLE_VAL  = 1'b0
) (
   input logic                   clk,
   input logic                   rst_n,
   piso_serializer_param_if.slave bus
);
`ifdef PISO_PARITY_EN
   localparam int FRAME_LEN = DATA_W + 1;
`else
   localparam int FRAME_LEN = DATA_W;
`endif
   localparam int CW = $clog2(DATA_W + 1);
   typedef enum logic {IDLE, SHIFT} state_e;
   state_e            state_q;
   logic [DATA_W-1:0] hold_q, shift_q;
   logic [CW-1:0]     bit_cnt_q;
   logic              hold_full_q, serial_q, valid_q, start_q;
   logic              last_bit, load_now, in_ready, accept, first_bit, next_bit;
`ifdef PISO_PARITY_EN
   logic              par_q;
`endif
   function automatic logic [DATA_W-1:0] shifted(input logic [DATA_W-1:0] x);
      return MSB_FIRST ? {x[DATA_W-2:0], 1'b0} : {1'b0, x[DATA_W-1:1]};
   endfunction
   always_comb begin
      last_bit  = bit_cnt_q == CW'(FRAME_LEN - 1);
      load_now  = hold_full_q && (state_q == IDLE || last_bit);
      in_ready  = !hold_full_q || load_now;
      accept    = bus.in_valid && in_ready;
      first_bit = MSB_FIRST ? hold_q[DATA_W-1] : hold_q[0];
`ifdef PISO_PARITY_EN
      next_bit  = (bit_cnt_q == CW'(DATA_W - 1)) ? par_q : (MSB_FIRST ? shift_q[DATA_W-1] : shift_q[0]);
`else
      next_bit  = MSB_FIRST ? shift_q[DATA_W-1] : shift_q[0];
`endif
   end
   // shift_q always holds the not-yet-sent bits aligned so the next one sits at the output end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         serial_q    <= IDLE_VAL;
         valid_q     <= 1'b0;
         start_q     <= 1'b0;
`ifdef PISO_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         if (accept) begin
            hold_q      <= bus.in_data;
            hold_full_q <= 1'b1;
         end else if (load_now) begin
            hold_full_q <= 1'b0;
         end
         if (load_now) begin
            state_q   <= SHIFT;
            shift_q   <= shifted(hold_q);
            bit_cnt_q <= '0;
            serial_q  <= first_bit;
            valid_q   <= 1'b1;
            start_q   <= 1'b1;
`ifdef PISO_PARITY_EN
            par_q     <= ^hold_q;
`endif
         end else if (state_q == SHIFT && last_bit) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            serial_q  <= IDLE_VAL;
            valid_q   <= 1'b0;
            start_q   <= 1'b0;
         end else if (state_q == SHIFT) begin
            shift_q   <= shifted(shift_q);
            bit_cnt_q <= bit_cnt_q + 1'b1;
            serial_q  <= next_bit;
            start_q   <= 1'b0;
         end
      end
   end
   assign bus.in_ready     = in_ready;
   assign bus.serial_out   = serial_q;
   assign bus.serial_valid = valid_q;
   assign bus.frame_start  = start_q;
   assign bus.busy         = state_q == SHIFT || hold_full_q;
endmodule

// File: tb/tb_piso_serializer_param.sv
// tb_piso_serializer_param: scoreboard bench driving an LSB-first/idle-low and an MSB-first/idle-high instance in lockstep.
module tb_piso_serializer_param;
`ifdef PISO_PARITY_EN
   localparam int FL = 11;
`else
   localparam int FL = 10;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   logic [1:0] q_lsb[$];
   logic [1:0] q_msb[$];
   piso_serializer_param_if #(.DATA_W(10)) ifa ();
   piso_serializer_param_if #(.DATA_W(10)) ifb ();
   assign ifb.in_data  = ifa.in_data;
   assign ifb.in_valid = ifa.in_valid;
   piso_serializer_param #(.DATA_W(10), .MSB_FIRST(1'b0), .IDLE_VAL(1'b0)) dut_lsb (.clk(clk), .rst_n(rst_n), .bus(ifa));
   piso_serializer_param #(.DATA_W(10), .MSB_FIRST(1'b1), .IDLE_VAL(1'b1)) dut_msb (.clk(clk), .rst_n(rst_n), .bus(ifb));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // {bit, first-of-frame} entries in transmit order, parity last when enabled
   task automatic push_word(input logic [9:0] w);
      for (int i = 0; i < FL; i++) begin
         q_lsb.push_back({(i < 10) ? w[i] : ^w, i == 0});
         q_msb.push_back({(i < 10) ? w[9-i] : ^w, i == 0});
      end
   endtask
   always @(negedge clk) begin
      if (rst_n) begin
         if (ifa.serial_valid === 1'b1) begin
            if (q_lsb.size() == 0) check("lsb_extra_bit", 1, 0);
            else check("lsb_bit", {30'd0, ifa.serial_out, ifa.frame_start}, {30'd0, q_lsb.pop_front()});
         end else check("lsb_idle", {30'd0, ifa.serial_out, ifa.frame_start}, 32'd0);
         if (ifb.serial_valid === 1'b1) begin
            if (q_msb.size() == 0) check("msb_extra_bit", 1, 0);
            else check("msb_bit", {30'd0, ifb.serial_out, ifb.frame_start}, {30'd0, q_msb.pop_front()});
         end else check("msb_idle", {30'd0, ifb.serial_out, ifb.frame_start}, 32'd2);
         if (ifa.in_valid && ifa.in_ready) push_word(ifa.in_data);
      end
   end
   task automatic send_one(input logic [9:0] w, output int stall);
      bit done;
      done = 1'b0;
      stall = 0;
      ifa.in_valid = 1'b1;
      ifa.in_data = w;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (ifa.in_ready) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end else stall++;
      end
      check("accept_done", {31'd0, done}, 32'd1);
   endtask
   task automatic measure(input int frames, input string tag);
      int n, t;
      n = 0;
      t = 0;
      while (ifa.serial_valid !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_wait"}, {31'd0, t < 50}, 32'd1);
      while (ifa.serial_valid === 1'b1 && n < 200) begin
         check({tag, "_fstart"}, {31'd0, ifa.frame_start}, {31'd0, (n % FL) == 0});
         n++;
         @(negedge clk);
      end
      check({tag, "_len"}, n, frames * FL);
   endtask
   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, {31'd0, ifa.serial_valid | ifb.serial_valid}, 32'd0);
      check({tag, "_out"}, {30'd0, ifb.serial_out, ifa.serial_out}, 32'd2);
      check({tag, "_fstart"}, {30'd0, ifb.frame_start, ifa.frame_start}, 32'd0);
      check({tag, "_busy"}, {30'd0, ifb.busy, ifa.busy}, 32'd0);
      check({tag, "_ready"}, {30'd0, ifb.in_ready, ifa.in_ready}, 32'd3);
   endtask
   initial begin
      int s1, s2, s3;
      ifa.in_valid = 1'b0;
      ifa.in_data = '0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;
      send_one(10'h2B5, s1);
      ifa.in_valid = 1'b0;
      check("single_busy", {31'd0, ifa.busy}, 32'd1);
      measure(1, "single");
      check("single_idle_busy", {31'd0, ifa.busy}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      fork
         begin
            send_one(10'h3FF, s1);
            send_one(10'h000, s2);
            send_one(10'h155, s3);
            ifa.in_valid = 1'b0;
         end
         measure(3, "b2b");
      join
      check("b2b_stall_w1", s1, 0);
      check("b2b_stall_w2", s2, 0);
      check("b2b_stall_w3", s3, FL - 1);
      repeat (2) @(posedge clk);
      #1;
      send_one(10'h155, s1);
      send_one(10'h2AA, s2);
      ifa.in_valid = 1'b0;
      check("rst_hold_ready", {31'd0, ifa.in_ready}, 32'd0);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("midrst");
      q_lsb.delete();
      q_msb.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", {31'd0, ifa.busy}, 32'd0);
      check("post_rst_valid", {31'd0, ifa.serial_valid}, 32'd0);
      @(posedge clk);
      #1;
      send_one(10'h001, s1);
      ifa.in_valid = 1'b0;
      measure(1, "after_rst");
      repeat (3) @(negedge clk);
      check("lsb_queue_empty", q_lsb.size(), 0);
      check("msb_queue_empty", q_msb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
